// File: rtl/rv_ctrl_pipe.sv
// rv_ctrl_pipe: pipelined control unit for the 5-stage RV32I core.
// Decodes the IF/ID instruction, carries the control bundle through
// ID/EX, EX/MEM and MEM/WB, and raises stall_o on data hazards.
// Optional macro RV_CTRL_FWD_EN: stall only on load-use and drive the
// EX operand forward selects; otherwise every RAW hazard stalls and the
// forward selects are tied to 00.
//
// Stall handshake: stall_o=1 means the instruction in IF/ID was not
// consumed this cycle; upstream must hold PC, instr_i and instr_vld_i
// unchanged until a cycle with stall_o=0. flush_i always wins and
// forces stall_o=0.
module rv_ctrl_pipe #(
    parameter int REG_AW    = 5,
    parameter int ALU_OP_W  = 2,
    parameter int RF_BYPASS = 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [31:0]         instr_i,
    input  logic                instr_vld_i,
    input  logic                flush_i,
    output logic                stall_o,
    output logic                illegal_o,
    output logic                ex_branch_o,
    output logic [ALU_OP_W-1:0] ex_alu_op_o,
    output logic                ex_alu_src_o,
    output logic [REG_AW-1:0]   ex_rs1_o,
    output logic [REG_AW-1:0]   ex_rs2_o,
    output logic [REG_AW-1:0]   ex_rd_o,
    output logic                mem_mem_read_o,
    output logic                mem_mem_write_o,
    output logic                wb_reg_write_o,
    output logic                wb_mem_to_reg_o,
    output logic [REG_AW-1:0]   wb_rd_o,
    output logic [1:0]          fwd_a_o,
    output logic [1:0]          fwd_b_o
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I_ALU = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Unused register fields are carried as 0 so they never match a producer.
    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic              mem_read;
        logic              mem_write;
        logic              alu_src;
        logic              branch;
        logic [1:0]        alu_op;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
    } ex_ctrl_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic              mem_read;
        logic              mem_write;
        logic [REG_AW-1:0] rd;
    } mem_ctrl_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic [REG_AW-1:0] rd;
    } wb_ctrl_t;

    ex_ctrl_t  id_c, ex_d, ex_q;
    mem_ctrl_t mem_q;
    wb_ctrl_t  wb_q;
    logic      id_illegal;
    logic      hazard;

    logic [REG_AW-1:0] f_rs1, f_rs2, f_rd;
    assign f_rs1 = REG_AW'(instr_i[19:15]);
    assign f_rs2 = REG_AW'(instr_i[24:20]);
    assign f_rd  = REG_AW'(instr_i[11:7]);

    // funct3/funct7 do not affect the control bundle.
    logic unused_funct;
    assign unused_funct = &{1'b0, instr_i[14:12], instr_i[31:25]};

    // True when a writing producer's rd matches a consumer rs (x0 never matches).
    function automatic logic rd_hit(input logic rw, input logic [REG_AW-1:0] rd,
                                    input logic [REG_AW-1:0] rs);
        return rw && (rd != '0) && (rd == rs);
    endfunction

    // ID decode: opcode to control bundle; unknown opcodes become bubbles.
    always_comb begin
        id_c       = '0;
        id_illegal = 1'b0;
        if (instr_vld_i) begin
            case (instr_i[6:0])
                OP_R: begin
                    id_c.reg_write = 1'b1;
                    id_c.alu_op    = 2'b10;
                    id_c.rs1       = f_rs1;
                    id_c.rs2       = f_rs2;
                    id_c.rd        = f_rd;
                end
                OP_I_ALU: begin
                    id_c.reg_write = 1'b1;
                    id_c.alu_src   = 1'b1;
                    id_c.alu_op    = 2'b11;
                    id_c.rs1       = f_rs1;
                    id_c.rd        = f_rd;
                end
                OP_LOAD: begin
                    id_c.reg_write  = 1'b1;
                    id_c.mem_to_reg = 1'b1;
                    id_c.mem_read   = 1'b1;
                    id_c.alu_src    = 1'b1;
                    id_c.rs1        = f_rs1;
                    id_c.rd         = f_rd;
                end
                OP_STORE: begin
                    id_c.mem_write = 1'b1;
                    id_c.alu_src   = 1'b1;
                    id_c.rs1       = f_rs1;
                    id_c.rs2       = f_rs2;
                end
                OP_BRANCH: begin
                    id_c.branch = 1'b1;
                    id_c.alu_op = 2'b01;
                    id_c.rs1    = f_rs1;
                    id_c.rs2    = f_rs2;
                end
                default: id_illegal = 1'b1;
            endcase
        end
    end

`ifdef RV_CTRL_FWD_EN
    // Only a load in EX cannot be forwarded in time: stall on load-use.
    always_comb begin
        hazard = ex_q.mem_read &&
                 (rd_hit(ex_q.reg_write, ex_q.rd, id_c.rs1) ||
                  rd_hit(ex_q.reg_write, ex_q.rd, id_c.rs2));
    end

    // Forward select per EX operand: EX/MEM (01) has priority over MEM/WB (10).
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (rd_hit(mem_q.reg_write, mem_q.rd, rs))
            return 2'b01;
        else if (rd_hit(wb_q.reg_write, wb_q.rd, rs))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign fwd_a_o = fwd_sel(ex_q.rs1);
    assign fwd_b_o = fwd_sel(ex_q.rs2);

    // With forwarding the register-file bypass setting has no effect.
    logic unused_bypass;
    assign unused_bypass = (RF_BYPASS != 0);
`else
    // Any in-flight writer of a used source register stalls ID.
    always_comb begin
        hazard = rd_hit(ex_q.reg_write, ex_q.rd, id_c.rs1)   ||
                 rd_hit(ex_q.reg_write, ex_q.rd, id_c.rs2)   ||
                 rd_hit(mem_q.reg_write, mem_q.rd, id_c.rs1) ||
                 rd_hit(mem_q.reg_write, mem_q.rd, id_c.rs2) ||
                 ((RF_BYPASS == 0) &&
                  (rd_hit(wb_q.reg_write, wb_q.rd, id_c.rs1) ||
                   rd_hit(wb_q.reg_write, wb_q.rd, id_c.rs2)));
    end

    assign fwd_a_o = 2'b00;
    assign fwd_b_o = 2'b00;
`endif

    // A flush or a stall both insert a bubble into EX; flush suppresses stall.
    assign stall_o   = rst_n_i & hazard & ~flush_i;
    assign illegal_o = rst_n_i & id_illegal;

    // ID/EX next value: bubble on stall or flush, otherwise the decoded bundle.
    always_comb begin
        ex_d = id_c;
        if (hazard || flush_i)
            ex_d = '0;
    end

    // Stage registers: advance every cycle, cleared to bubbles on reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= '{reg_write: ex_q.reg_write, mem_to_reg: ex_q.mem_to_reg,
                       mem_read: ex_q.mem_read, mem_write: ex_q.mem_write,
                       rd: ex_q.rd};
            wb_q  <= '{reg_write: mem_q.reg_write, mem_to_reg: mem_q.mem_to_reg,
                       rd: mem_q.rd};
        end
    end

    // ALU op output is zero-extended beyond the two defined bits.
    always_comb begin
        ex_alu_op_o      = '0;
        ex_alu_op_o[1:0] = ex_q.alu_op;
    end

    assign ex_branch_o     = ex_q.branch;
    assign ex_alu_src_o    = ex_q.alu_src;
    assign ex_rs1_o        = ex_q.rs1;
    assign ex_rs2_o        = ex_q.rs2;
    assign ex_rd_o         = ex_q.rd;
    assign mem_mem_read_o  = mem_q.mem_read;
    assign mem_mem_write_o = mem_q.mem_write;
    assign wb_reg_write_o  = wb_q.reg_write;
    assign wb_mem_to_reg_o = wb_q.mem_to_reg;
    assign wb_rd_o         = wb_q.rd;

endmodule

// File: tb/tb_rv_ctrl_pipe.sv
// tb_rv_ctrl_pipe: directed and randomized bench for rv_ctrl_pipe with a
// queue-based instruction-level reference model checked every cycle.
module tb_rv_ctrl_pipe;
    localparam int REG_AW    = 5;
    localparam int ALU_OP_W  = 2;
    localparam int RF_BYPASS = 1;

    localparam logic [31:0] I_ADD   = 32'h002081B3; // add x3,x1,x2
    localparam logic [31:0] I_SUB   = 32'h40118233; // sub x4,x3,x1
    localparam logic [31:0] I_LW    = 32'h0000A283; // lw x5,0(x1)
    localparam logic [31:0] I_ADD6  = 32'h00528333; // add x6,x5,x5
    localparam logic [31:0] I_ILL   = 32'h0000007F;
    localparam logic [31:0] I_ADDI0 = 32'h00100013; // addi x0,x0,1
    localparam logic [31:0] I_ADD60 = 32'h00000333; // add x6,x0,x0

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0]         instr;
    logic                instr_vld;
    logic                flush;
    logic                stall_o, illegal_o, ex_branch_o, ex_alu_src_o;
    logic [ALU_OP_W-1:0] ex_alu_op_o;
    logic [REG_AW-1:0]   ex_rs1_o, ex_rs2_o, ex_rd_o, wb_rd_o;
    logic                mem_mem_read_o, mem_mem_write_o;
    logic                wb_reg_write_o, wb_mem_to_reg_o;
    logic [1:0]          fwd_a_o, fwd_b_o;

    rv_ctrl_pipe #(.REG_AW(REG_AW), .ALU_OP_W(ALU_OP_W), .RF_BYPASS(RF_BYPASS)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .instr_i(instr), .instr_vld_i(instr_vld),
        .flush_i(flush), .stall_o(stall_o), .illegal_o(illegal_o),
        .ex_branch_o(ex_branch_o), .ex_alu_op_o(ex_alu_op_o),
        .ex_alu_src_o(ex_alu_src_o), .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o),
        .ex_rd_o(ex_rd_o), .mem_mem_read_o(mem_mem_read_o),
        .mem_mem_write_o(mem_mem_write_o), .wb_reg_write_o(wb_reg_write_o),
        .wb_mem_to_reg_o(wb_mem_to_reg_o), .wb_rd_o(wb_rd_o),
        .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // One record per instruction slot; pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB.
    typedef struct {
        logic       rw, m2r, mr, mw, asrc, br;
        logic [1:0] op;
        logic [4:0] rs1, rs2, rd;
    } rec_t;

    rec_t pipe[$];
    logic m_stall = 1'b0;

    function automatic rec_t bubble();
        rec_t r;
        r = '{rw: 0, m2r: 0, mr: 0, mw: 0, asrc: 0, br: 0, op: 0, rs1: 0, rs2: 0, rd: 0};
        return r;
    endfunction

    // Opcode table from the ISA class list; sources unused by a class read as 0.
    function automatic rec_t m_decode(input logic [31:0] ins, input logic v, output logic ill);
        rec_t r = bubble();
        ill = 1'b0;
        if (v) begin
            case (ins[6:0])
                7'b0110011: begin r.rw = 1; r.op = 2; r.rs1 = ins[19:15]; r.rs2 = ins[24:20]; r.rd = ins[11:7]; end
                7'b0010011: begin r.rw = 1; r.asrc = 1; r.op = 3; r.rs1 = ins[19:15]; r.rd = ins[11:7]; end
                7'b0000011: begin r.rw = 1; r.m2r = 1; r.mr = 1; r.asrc = 1; r.rs1 = ins[19:15]; r.rd = ins[11:7]; end
                7'b0100011: begin r.mw = 1; r.asrc = 1; r.rs1 = ins[19:15]; r.rs2 = ins[24:20]; end
                7'b1100011: begin r.br = 1; r.op = 1; r.rs1 = ins[19:15]; r.rs2 = ins[24:20]; end
                default: ill = 1'b1;
            endcase
        end
        return r;
    endfunction

    function automatic logic writes(input rec_t p, input logic [4:0] rs);
        return p.rw && p.rd != 0 && p.rd == rs;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
`ifdef RV_CTRL_FWD_EN
        if (writes(pipe[1], rs)) return 2'b01;
        if (writes(pipe[2], rs)) return 2'b10;
`endif
        return rs == 5'd0 ? 2'b00 : 2'b00;
    endfunction

    // Compare process: every cycle, outputs versus model, then advance model.
    always @(negedge clk) begin
        rec_t id, e, m, w;
        logic ill, hz;
        int depth;
        if (!rst_n) begin
            chk("rst_stall", stall_o, 0);      chk("rst_illegal", illegal_o, 0);
            chk("rst_ex_rd", ex_rd_o, 0);      chk("rst_ex_op", ex_alu_op_o, 0);
            chk("rst_mem_rd", mem_mem_read_o, 0); chk("rst_wb_rw", wb_reg_write_o, 0);
            chk("rst_wb_rd", wb_rd_o, 0);
            pipe = {bubble(), bubble(), bubble()};
            m_stall = 1'b0;
        end else begin
            id = m_decode(instr, instr_vld, ill);
            e = pipe[0]; m = pipe[1]; w = pipe[2];
            hz = 1'b0;
`ifdef RV_CTRL_FWD_EN
            hz = e.mr && (writes(e, id.rs1) || writes(e, id.rs2));
`else
            depth = (RF_BYPASS != 0) ? 2 : 3;
            for (int d = 0; d < depth; d++)
                if (writes(pipe[d], id.rs1) || writes(pipe[d], id.rs2)) hz = 1'b1;
`endif
            m_stall = hz && !flush;
            chk("stall", stall_o, m_stall);
            chk("illegal", illegal_o, ill);
            chk("ex_branch", ex_branch_o, e.br);
            chk("ex_alu_op", ex_alu_op_o, e.op);
            chk("ex_alu_src", ex_alu_src_o, e.asrc);
            chk("ex_rs1", ex_rs1_o, e.rs1);
            chk("ex_rs2", ex_rs2_o, e.rs2);
            chk("ex_rd", ex_rd_o, e.rd);
            chk("mem_read", mem_mem_read_o, m.mr);
            chk("mem_write", mem_mem_write_o, m.mw);
            chk("wb_reg_write", wb_reg_write_o, w.rw);
            chk("wb_mem_to_reg", wb_mem_to_reg_o, w.m2r);
            chk("wb_rd", wb_rd_o, w.rd);
            chk("fwd_a", fwd_a_o, m_fwd(e.rs1));
            chk("fwd_b", fwd_b_o, m_fwd(e.rs2));
            pipe.push_front((hz || flush) ? bubble() : id);
            void'(pipe.pop_back());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic v, input logic f);
        instr = ins; instr_vld = v; flush = f;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0] ops [6];
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111};
        ins = $urandom;
        ins[6:0]   = ops[$urandom_range(0, 5)];
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        return ins;
    endfunction

    // Watchdog: the run is cycle-bounded, this only guards a broken bench.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        pipe = {bubble(), bubble(), bubble()};
        rst_n = 1'b0;
        drive(I_ILL, 1, 0);
        #2;
        chk("reset_illegal_gated", illegal_o, 0);
        chk("reset_stall", stall_o, 0);
        @(posedge clk); @(posedge clk); #2;
        drive(0, 0, 0);
        rst_n = 1'b1;

        // Decode latency
        tick(); drive(I_ADD, 1, 0);
        tick(); drive(0, 0, 0);
        @(negedge clk);
        chk("lat_ex_alu_op", ex_alu_op_o, 2); chk("lat_ex_rd", ex_rd_o, 3);
        tick(); tick();
        @(negedge clk);
        chk("lat_wb_rw", wb_reg_write_o, 1); chk("lat_wb_rd", wb_rd_o, 3);
        chk("lat_wb_m2r", wb_mem_to_reg_o, 0);
        tick(); tick();

`ifdef RV_CTRL_FWD_EN
        // RAW with forwarding: no stall, sub forwarded from EX/MEM
        drive(I_ADD, 1, 0);
        tick(); drive(I_SUB, 1, 0);
        @(negedge clk); chk("raw_fwd_nostall", stall_o, 0);
        tick(); drive(0, 0, 0);
        @(negedge clk); chk("raw_fwd_ex_rd", ex_rd_o, 4);
        chk("raw_fwd_a", fwd_a_o, 2'b01); chk("raw_fwd_b", fwd_b_o, 2'b00);
        tick(); tick(); tick();
        // Load-use: one stall cycle, then operands forwarded from MEM/WB
        drive(I_LW, 1, 0);
        tick(); drive(I_ADD6, 1, 0);
        @(negedge clk); chk("lu_stall1", stall_o, 1);
        tick();
        @(negedge clk); chk("lu_stall2", stall_o, 0); chk("lu_bubble_rd", ex_rd_o, 0);
        chk("lu_mem_read", mem_mem_read_o, 1);
        tick(); drive(0, 0, 0);
        @(negedge clk); chk("lu_ex_rd", ex_rd_o, 6);
        chk("lu_fwd_a", fwd_a_o, 2'b10); chk("lu_fwd_b", fwd_b_o, 2'b10);
`else
        // RAW without forwarding: two stall cycles, then sub in EX
        drive(I_ADD, 1, 0);
        tick(); drive(I_SUB, 1, 0);
        @(negedge clk); chk("raw_stall1", stall_o, 1);
        tick();
        @(negedge clk); chk("raw_stall2", stall_o, 1); chk("raw_bubble_rd", ex_rd_o, 0);
        tick();
        @(negedge clk); chk("raw_stall3", stall_o, 0);
        tick(); drive(0, 0, 0);
        @(negedge clk); chk("raw_ex_rd", ex_rd_o, 4); chk("raw_ex_op", ex_alu_op_o, 2);
        tick(); tick(); tick();
        // Load-use without forwarding stalls for two cycles
        drive(I_LW, 1, 0);
        tick(); drive(I_ADD6, 1, 0);
        @(negedge clk); chk("lu_stall1", stall_o, 1);
        tick();
        @(negedge clk); chk("lu_stall2", stall_o, 1); chk("lu_mem_read", mem_mem_read_o, 1);
        tick();
        @(negedge clk); chk("lu_stall3", stall_o, 0);
        tick(); drive(0, 0, 0);
        @(negedge clk); chk("lu_ex_rd", ex_rd_o, 6);
`endif
        tick(); tick(); tick();

        // Flush beats stall
        drive(I_LW, 1, 0);
        tick(); drive(I_ADD6, 1, 1);
        @(negedge clk); chk("flush_stall", stall_o, 0);
        tick(); drive(0, 0, 0);
        @(negedge clk); chk("flush_ex_rd", ex_rd_o, 0); chk("flush_ex_rs1", ex_rs1_o, 0);
        chk("flush_mem_read", mem_mem_read_o, 1);
        tick(); tick(); tick();

        // Illegal opcode and x0 destination
        drive(I_ILL, 1, 0);
        @(negedge clk); chk("ill_flag", illegal_o, 1);
        tick(); drive(I_ADDI0, 1, 0);
        @(negedge clk); chk("ill_ex_src", ex_alu_src_o, 0); chk("ill_clear", illegal_o, 0);
        tick(); drive(I_ADD60, 1, 0);
        @(negedge clk); chk("x0_nostall", stall_o, 0); chk("x0_ex_op", ex_alu_op_o, 3);
        tick(); drive(0, 0, 0);

        // Randomized traffic with a mid-stream asynchronous reset
        for (int c = 0; c < 1500; c++) begin
            tick();
            if (c == 700) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("mid_rst_stall", stall_o, 0); chk("mid_rst_ex_rd", ex_rd_o, 0);
                chk("mid_rst_wb_rw", wb_reg_write_o, 0); chk("mid_rst_fwd_a", fwd_a_o, 0);
                @(posedge clk); @(posedge clk); #2;
                rst_n = 1'b1;
            end
            if (!m_stall) drive(rand_instr(), ($urandom_range(0, 7) != 0), 1'b0);
            flush = ($urandom_range(0, 9) == 0);
        end
        tick(); drive(0, 0, 0);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rv_ctrl_pipe.md
Name: rv_ctrl_pipe

Overview:
- Pipelined control unit for the 5-stage RV32I core.
- Decodes the instruction presented in ID into a control bundle and carries it through ID/EX, EX/MEM and MEM/WB registers.
- Detects RAW/load-use hazards and drives `stall_o`; accepts a branch flush from EX.
- Sits between the IF/ID register (external) and the datapath stage muxes; replaces the purely combinational per-opcode decode.

Parameters:
- REG_AW, 5: register-address width for the rs1/rs2/rd fields and rd tracking.
- ALU_OP_W, 2: width of the alu_op outputs. Minimum 2; bits above [1:0] are driven 0.
- RF_BYPASS, 1: 1 = register file is write-first, so the WB stage is never a hazard source. 0 = the WB stage is also compared.

Ports:
- clk_i  in  1  core clock
- rst_n_i  in  1  asynchronous active-low reset
- instr_i  in  32  instruction held in IF/ID; held stable by upstream while stall_o=1
- instr_vld_i  in  1  instr_i is a real instruction; 0 = bubble
- flush_i  in  1  branch taken, resolved in EX this cycle
- stall_o  out  1  hold PC and IF/ID this cycle
- illegal_o  out  1  instr_vld_i=1 with an unsupported opcode; combinational from ID
- ex_branch_o  out  1  EX-stage branch
- ex_alu_op_o  out  ALU_OP_W  EX-stage ALU operation class
- ex_alu_src_o  out  1  EX-stage ALU operand B select (1 = immediate)
- ex_rs1_o  out  REG_AW  EX-stage rs1 address
- ex_rs2_o  out  REG_AW  EX-stage rs2 address
- ex_rd_o  out  REG_AW  EX-stage rd address
- mem_mem_read_o  out  1  MEM-stage data-memory read
- mem_mem_write_o  out  1  MEM-stage data-memory write
- wb_reg_write_o  out  1  WB-stage register-file write enable
- wb_mem_to_reg_o  out  1  WB-stage writeback select (1 = memory data)
- wb_rd_o  out  REG_AW  WB-stage destination register
- fwd_a_o  out  2  EX operand A forward select (only with RV_CTRL_FWD_EN)
- fwd_b_o  out  2  EX operand B forward select (only with RV_CTRL_FWD_EN)

Behaviour:
- Decode from opcode instr_i[6:0]; flags are {reg_write, mem_to_reg, mem_read, mem_write, alu_src, branch}:
  - 0110011 R: reg_write, alu_op=10
  - 0010011 I-ALU: reg_write, alu_src, alu_op=11
  - 0000011 load: reg_write, mem_to_reg, mem_read, alu_src, alu_op=00
  - 0100011 store: mem_write, alu_src, alu_op=00
  - 1100011 branch: branch, alu_op=01
  - Any other opcode: illegal_o=1 and the instruction enters as a bubble.
- Bubble definition: all control flags 0, alu_op 0, rs1/rs2/rd 0.
- Register usage:
  - rs1 is used by all five classes; rs2 by R, store and branch.
  - rd is meaningful only when reg_write=1. Store/branch carry rd=0.
  - rd=0 never creates a hazard.
- Pipeline:
  - Each stage register advances every cycle.
  - Decode sampled at edge N appears on ex_* after edge N+1, mem_* after N+2, wb_* after N+3.
  - The EX/MEM and MEM/WB registers never stall.
- Hazard, without forwarding: stall_o=1 when a used ID rs equals a reg_write rd in EX or MEM (also WB if RF_BYPASS=0).
- Hazard, with forwarding: stall_o=1 only when EX holds a load (mem_read) whose rd equals a used ID rs.
- While stall_o=1: ID/EX loads a bubble; ID content is re-evaluated next cycle from the held instr_i.
- Flush:
  - flush_i=1: ID/EX loads a bubble and stall_o is forced to 0.
  - Flush beats stall when both occur in the same cycle.
  - The branch in EX still advances to MEM.
- Reset (asynchronous, rst_n_i=0): all stage registers become bubbles; every output is 0. Reset mid-stall releases the stall immediately.

Optional Feature:
- Macro: RV_CTRL_FWD_EN.
- Defined:
  - Stall only on load-use.
  - fwd_a_o/fwd_b_o compare ex_rs1/ex_rs2 against EX/MEM rd (reg_write, rd≠0) → 01, else MEM/WB rd → 10, else 00.
  - MEM has priority over WB.
- Undefined:
  - Full RAW stalls as above.
  - fwd_a_o/fwd_b_o are tied to 00.

Test Plan:
- Reset: assert rst_n_i=0 mid-stream → all outputs 0 asynchronously; after release, stall_o=0 and all stages hold bubbles.
- Decode latency: add x3,x1,x2 (0x002081B3) at edge 0 → edge 1: ex_alu_op_o=10, ex_rd_o=3; edge 3: wb_reg_write_o=1, wb_rd_o=3, wb_mem_to_reg_o=0.
- Load-use, FWD_EN: lw x5,0(x1) (0x0000A283) then add x6,x5,x5 (0x00528333):
  - stall_o=1 for exactly 1 cycle, with an EX bubble inserted.
  - Next cycle the add is in EX with fwd_a_o=fwd_b_o=10.
- RAW, no FWD, RF_BYPASS=1: add x3,x1,x2 then sub x4,x3,x1 (0x40118233) → stall_o=1 for 2 cycles, then the sub enters EX.
- Flush with stall: same load-use pair with flush_i=1 in the stall cycle → stall_o=0 that cycle; EX holds a bubble next cycle; mem_mem_read_o=1 for the load.
- Illegal/x0: 0x0000007F → illegal_o=1, EX bubble. addi x0,x0,1 (0x00100013) followed by add x6,x0,x0 → no stall.
